// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single mem_dpi port between the IFU (read-only) and
// the LSU (read/write). One request in flight at a time; each request walks
// IDLE -> WAIT -> ACCESS -> RESP, with WAIT lasting LATENCY cycles (skipped
// when LATENCY=0).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration. Without it,
// fixed priority applies and the LSU wins when both masters request.
module mem_arbiter #(
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_wen,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic [31:0] ls_rsp_data,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [7:0]  lat_wmask;
  logic        lat_wen;
  logic        lat_ls;

  logic        pick_ls;
  logic        hs;
  logic        go_access;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic [7:0]  nxt_wmask;
  logic        nxt_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [7:0]  acc_wmask;
  logic        acc_wen;

`ifdef MEM_ARB_RR_EN
  logic        last_ls;
`endif

  // Pick the winner among current requesters; ready is offered only in IDLE.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_ls = ls_req_valid && (!if_req_valid || !last_ls);
`else
    pick_ls = ls_req_valid;
`endif
    if_req_ready = rst_n && (state == IDLE) && if_req_valid && !pick_ls;
    ls_req_ready = rst_n && (state == IDLE) && pick_ls;
    hs           = if_req_ready || ls_req_ready;
  end

  // Select the incoming request in IDLE, otherwise the latched one, as the access source.
  always_comb begin
    nxt_wen   = pick_ls && ls_req_wen;
    nxt_addr  = pick_ls ? ls_req_addr : if_req_addr;
    nxt_wdata = nxt_wen ? ls_req_wdata : '0;
    nxt_wmask = nxt_wen ? ls_req_wmask : '0;
    if (state == IDLE) begin
      acc_wen   = nxt_wen;
      acc_addr  = nxt_addr;
      acc_wdata = nxt_wdata;
      acc_wmask = nxt_wmask;
    end else begin
      acc_wen   = lat_wen;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wmask = lat_wmask;
    end
    go_access = ((state == IDLE) && hs && (LATENCY == 0)) ||
                ((state == WAIT) && (cnt <= 8'd1));
  end

  // Request FSM; the memory port is loaded only on entry to ACCESS, so mem_valid
  // is high for exactly the single ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_wmask    <= '0;
      lat_wen      <= 1'b0;
      lat_ls       <= 1'b0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= '0;
      mem_valid    <= 1'b0;
      mem_wen      <= 1'b0;
      mem_raddr    <= '0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls      <= 1'b0;
`endif
    end else begin
      mem_valid <= go_access;
      mem_wen   <= go_access && acc_wen;
      mem_raddr <= go_access ? acc_addr  : '0;
      mem_waddr <= go_access ? acc_addr  : '0;
      mem_wdata <= go_access ? acc_wdata : '0;
      mem_wmask <= go_access ? acc_wmask : '0;
      case (state)
        IDLE: begin
          if (hs) begin
            lat_addr  <= nxt_addr;
            lat_wdata <= nxt_wdata;
            lat_wmask <= nxt_wmask;
            lat_wen   <= nxt_wen;
            lat_ls    <= pick_ls;
`ifdef MEM_ARB_RR_EN
            last_ls   <= pick_ls;
`endif
            if (LATENCY == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= LATENCY[7:0];
            end
          end
        end
        WAIT: begin
          if (cnt <= 8'd1) begin
            state <= ACCESS;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACCESS: begin
          if (lat_ls) begin
            ls_rsp_valid <= 1'b1;
            ls_rsp_data  <= lat_wen ? '0 : mem_rdata;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          if (lat_ls ? ls_rsp_ready : if_rsp_ready) begin
            ls_rsp_valid <= 1'b0;
            if_rsp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
